// File: rtl/booth_mac_accumulator_if.sv
// Bus between the Booth multiplier back end and its producer/consumer.
// It carries the run request, the product input handshake, and the
// result output handshake. The master is the environment side and the
// slave is the accumulator.
interface booth_mac_accumulator_if #(
    parameter int ACC_W = 40,
    parameter int CNT_W = 8
);
    logic                    start;
    logic [CNT_W-1:0]        len;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [31:0]      product;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] sum;
    logic                    overflow;
    logic                    busy;

    modport master (
        output start, len, in_valid, product, out_ready,
        input  in_ready, out_valid, sum, overflow, busy
    );

    modport slave (
        input  start, len, in_valid, product, out_ready,
        output in_ready, out_valid, sum, overflow, busy
    );
endinterface

// File: rtl/booth_mac_accumulator.sv
// Saturating signed multiply-accumulate back end. It sums a run of `len`
// 32-bit signed products into an ACC_W-bit accumulator and then holds the
// result on an output valid/ready handshake. ACC_W must be at least 33.
// All outputs decode from registered state, so there is no combinational
// path from in_valid or out_ready to any output.
module booth_mac_accumulator #(
    parameter int ACC_W = 40,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    booth_mac_accumulator_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    ovf_q, ovf_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    // The sum is one bit wider than the accumulator, so it can never wrap.
    // The top two bits then disagree exactly when the true value is out of range.
    logic signed [ACC_W:0]   sum_w;

    // Clamp the widened sum back into the accumulator range.
    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] w);
        if (w[ACC_W] != w[ACC_W-1]) begin
            return w[ACC_W] ? ACC_MIN : ACC_MAX;
        end
        return $signed(w[ACC_W-1:0]);
    endfunction

    // Report whether the widened sum lies outside the accumulator range.
    function automatic logic sat_hit(input logic signed [ACC_W:0] w);
        return w[ACC_W] ^ w[ACC_W-1];
    endfunction

    // The accumulator and the product are both sign-extended to ACC_W+1 bits.
    // For the product, bit 31 is the sign bit.
    assign sum_w = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-31){bus.product[31]}}, bus.product};

    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.sum       = acc_q;
    assign bus.overflow  = ovf_q;

    // State, accumulator, sticky overflow and remaining-count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: start a run, take products, then hold the result.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = bus.len;
                    state_d = (bus.len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (bus.in_valid) begin
                    acc_d = sat_acc(sum_w);
                    if (sat_hit(sum_w)) begin
                        ovf_d = 1'b1;
                    end
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
